muxn_arb: RTL and testbench

MUXN_ARB -- requirements
Module: muxn_arb

---
 rtl/muxn_arb.sv | 81 ++++++++
 tb/tb_muxn_arb.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muxn_arb.sv
// N-channel valid/ready multiplexer with fixed-select or round-robin arbitration.
// One registered output stage; a new word loads whenever the stage is empty or draining.
module muxn_arb #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic             ld;
  logic             gnt_vld;
  logic [SELW-1:0]  gnt;
  logic [SELW-1:0]  ptr;
  logic [WIDTH-1:0] gnt_data;

  assign ld = !out_valid || out_ready;

  // Round-robin picks the valid channel at the smallest rotational distance past ptr.
  always_comb begin
    int best_d;
    int d;
    gnt_vld = 1'b0;
    gnt     = '0;
    best_d  = NCH;
    d       = 0;
    if (!mode) begin
      for (int i = 0; i < NCH; i++) begin
        if (sel == SELW'(i) && in_valid[i]) begin
          gnt_vld = 1'b1;
          gnt     = SELW'(i);
        end
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        d = (i + NCH - 1 - int'(ptr)) % NCH;
        if (in_valid[i] && d < best_d) begin
          best_d  = d;
          gnt_vld = 1'b1;
          gnt     = SELW'(i);
        end
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt == SELW'(i)) gnt_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign in_ready = (rst_n && ld && gnt_vld) ? (NCH'(1) << gnt) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= SELW'(NCH - 1);
    end else if (ld) begin
      out_valid <= gnt_vld;
      if (gnt_vld) begin
        out_data <= gnt_data;
        out_ch   <= gnt;
        if (mode) ptr <= gnt;
      end
    end
  end

endmodule

// File: tb/tb_muxn_arb.sv
// Randomized and directed bench for muxn_arb: a 4-channel and a 5-channel instance
// checked against a transaction-level reference model.
module tb_muxn_arb;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic        out_ready;

  logic [1:0]   sel4;
  logic [127:0] data4;
  logic [3:0]   valid4;
  logic [3:0]   in_ready4;
  logic [31:0]  out_data4;
  logic [1:0]   out_ch4;
  logic         out_valid4;

  logic [2:0]  sel5;
  logic [39:0] data5;
  logic [4:0]  valid5;
  logic [4:0]  in_ready5;
  logic [7:0]  out_data5;
  logic [2:0]  out_ch5;
  logic        out_valid5;

  int n_vec = 0;
  int n_err = 0;

  // reference state, index 0 = 4-channel instance, 1 = 5-channel instance
  bit          m_valid [2];
  logic [63:0] m_data  [2];
  int          m_ch    [2];
  int          m_ptr   [2];
  int          m_nch   [2] = '{4, 5};

  muxn_arb #(.WIDTH(32), .NCH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel4), .in_data(data4),
    .in_valid(valid4), .in_ready(in_ready4), .out_data(out_data4),
    .out_ch(out_ch4), .out_valid(out_valid4), .out_ready(out_ready)
  );

  muxn_arb #(.WIDTH(8), .NCH(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel5), .in_data(data5),
    .in_valid(valid5), .in_ready(in_ready5), .out_data(out_data5),
    .out_ch(out_ch5), .out_valid(out_valid5), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_grant(input bit md, input int s, input logic [15:0] v,
                                      input int p, input int n, output bit gv, output int g);
    int order[$];
    gv = 0;
    g  = 0;
    if (!md) begin
      if (s < n && v[s]) begin
        gv = 1;
        g  = s;
      end
    end else begin
      for (int k = 1; k <= n; k++) order.push_back((p + k) % n);
      foreach (order[j]) begin
        if (!gv && v[order[j]]) begin
          gv = 1;
          g  = order[j];
        end
      end
    end
  endfunction

  function automatic void model_reset();
    for (int u = 0; u < 2; u++) begin
      m_valid[u] = 0;
      m_data[u]  = '0;
      m_ch[u]    = 0;
      m_ptr[u]   = m_nch[u] - 1;
    end
  endfunction

  // Called just after a rising edge with fresh inputs already applied.
  task automatic cycle_check(input int want4 = -1, input int want5 = -1);
    bit   gv[2];
    int   g[2];
    bit   ldm[2];
    logic [15:0] exp_rdy[2];
    #4;
    model_grant(mode, int'(sel4), 16'(valid4), m_ptr[0], 4, gv[0], g[0]);
    model_grant(mode, int'(sel5), 16'(valid5), m_ptr[1], 5, gv[1], g[1]);
    for (int u = 0; u < 2; u++) begin
      ldm[u] = rst_n && (!m_valid[u] || out_ready);
      exp_rdy[u] = (ldm[u] && gv[u]) ? (16'd1 << g[u]) : 16'd0;
    end
    chk("rdy4", 64'(in_ready4), 64'(exp_rdy[0]));
    chk("rdy5", 64'(in_ready5), 64'(exp_rdy[1]));
    if (want4 >= 0) chk("rdy4_dir", 64'(in_ready4), 64'(want4));
    if (want5 >= 0) chk("rdy5_dir", 64'(in_ready5), 64'(want5));
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      for (int u = 0; u < 2; u++) begin
        if (ldm[u]) begin
          m_valid[u] = gv[u];
          if (gv[u]) begin
            m_data[u] = (u == 0) ? 64'(data4[g[u]*32 +: 32]) : 64'(data5[g[u]*8 +: 8]);
            m_ch[u]   = g[u];
            if (mode) m_ptr[u] = g[u];
          end
        end
      end
    end
    #1;
    chk("ovalid4", 64'(out_valid4), 64'(m_valid[0]));
    chk("ovalid5", 64'(out_valid5), 64'(m_valid[1]));
    chk("odata4", 64'(out_data4), m_data[0]);
    chk("odata5", 64'(out_data5), m_data[1]);
    chk("och4", 64'(out_ch4), 64'(m_ch[0]));
    chk("och5", 64'(out_ch5), 64'(m_ch[1]));
  endtask

  task automatic set_distinct_data();
    for (int i = 0; i < 4; i++) data4[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
    for (int i = 0; i < 5; i++) data5[i*8 +: 8] = 8'h50 + 8'(i);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    model_reset();
    valid4 = 4'hF;
    valid5 = 5'h1F;
    mode   = 1'b1;
    out_ready = 1'b1;
    cycle_check(0, 0);
    cycle_check(0, 0);
    rst_n = 1'b1;
  endtask

  logic [31:0] held;

  initial begin
    rst_n = 1'b1; mode = 1'b0; out_ready = 1'b0;
    sel4 = '0; sel5 = '0; valid4 = '0; valid5 = '0; data4 = '0; data5 = '0;
    model_reset();
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_ovalid", 64'(out_valid4), 64'd0);
    chk("rst_odata", 64'(out_data4), 64'd0);
    do_reset();

    // fixed select of channel 2
    mode = 1'b0; sel4 = 2'd2; valid4 = 4'b1111; out_ready = 1'b1;
    sel5 = 3'd4; valid5 = 5'b10000;
    data4 = '0; data4[2*32 +: 32] = 32'hA5A5_0002;
    cycle_check(4'b0100, 5'b10000);
    chk("sel2_data", 64'(out_data4), 64'h0000_0000_A5A5_0002);
    chk("sel2_ch", 64'(out_ch4), 64'd2);

    // round-robin from reset: 0,1,2,3,0,1 at one word per cycle
    do_reset();
    set_distinct_data();
    mode = 1'b1; valid4 = 4'hF; valid5 = 5'h1F; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle_check(1 << (i % 4), 1 << (i % 5));
      chk("rr_seq", 64'(out_ch4), 64'(i % 4));
      chk("rr_valid", 64'(out_valid4), 64'd1);
    end

    // backpressure for 3 cycles, then drain and refill together
    held = out_data4;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle_check(0, 0);
      chk("bp_hold", 64'(out_data4), 64'(held));
    end
    out_ready = 1'b1;
    cycle_check(4'b0100);
    chk("bp_refill_ch", 64'(out_ch4), 64'd2);
    chk("bp_refill_data", 64'(out_data4), 64'h0000_0000_C0DE_0002);

    // sparse valids with ptr=1: 3, 1, 3
    do_reset();
    mode = 1'b1; valid4 = 4'b0010; out_ready = 1'b1;
    cycle_check(4'b0010);
    valid4 = 4'b1010;
    cycle_check(4'b1000);
    chk("sparse_g3", 64'(out_ch4), 64'd3);
    cycle_check(4'b0010);
    chk("sparse_g1", 64'(out_ch4), 64'd1);
    cycle_check(4'b1000);

    // out-of-range select on the 5-channel instance
    mode = 1'b0; sel5 = 3'd1; valid5 = 5'h1F; out_ready = 1'b1;
    cycle_check(-1, 5'b00010);
    out_ready = 1'b0;
    for (int s = 5; s < 8; s++) begin
      sel5 = 3'(s);
      cycle_check(-1, 0);
      chk("oor_hold", 64'(out_valid5), 64'd1);
    end
    out_ready = 1'b1;
    sel5 = 3'd5;
    cycle_check(-1, 0);
    chk("oor_drain", 64'(out_valid5), 64'd0);
    sel5 = 3'd7;
    cycle_check(-1, 0);
    chk("oor_empty", 64'(out_valid5), 64'd0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      mode      = 1'($urandom_range(0, 1));
      sel4      = 2'($urandom);
      sel5      = 3'($urandom_range(0, 7));
      valid4    = 4'($urandom);
      valid5    = 5'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) data4[i*32 +: 32] = $urandom;
      for (int i = 0; i < 5; i++) data5[i*8 +: 8] = 8'($urandom);
      cycle_check();
    end

    // asynchronous reset mid-cycle while holding a word
    mode = 1'b0; sel4 = 2'd3; valid4 = 4'hF; out_ready = 1'b1;
    sel5 = 3'd2; valid5 = 5'h1F;
    set_distinct_data();
    cycle_check();
    chk("pre_arst_valid", 64'(out_valid4), 64'd1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_valid4", 64'(out_valid4), 64'd0);
    chk("arst_data4", 64'(out_data4), 64'd0);
    chk("arst_ch4", 64'(out_ch4), 64'd0);
    chk("arst_valid5", 64'(out_valid5), 64'd0);
    @(posedge clk); #1;
    cycle_check(0, 0);
    rst_n = 1'b1;
    mode = 1'b1; valid4 = 4'hF; valid5 = 5'h1F;
    cycle_check(4'b0001, 5'b00001);
    chk("arst_first_rr", 64'(out_ch4), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
